// File: rtl/ift_stim_sequencer.sv
// Stimulus replay table for IFT-instrumented datapaths; records the first entry that drives taint to c_t.
// Optional macro IFT_SEQ_LOOP_EN: continuous replay across passes with a stop input.
module ift_stim_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned TW    = 32,
  parameter int unsigned CW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [2+2*TW+CW-1:0]   wr_data,
  input  logic [AW:0]            len,
  input  logic                   start,
`ifdef IFT_SEQ_LOOP_EN
  input  logic                   stop,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   wr_err,
  output logic                   a,
  output logic                   b,
  output logic [TW-1:0]          a_t,
  output logic [TW-1:0]          b_t,
  input  logic [TW-1:0]          c_t,
  output logic                   taint_seen,
  output logic [AW-1:0]          first_idx,
  output logic [AW-1:0]          cur_idx
);

  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic          a;
    logic          b;
    logic [TW-1:0] a_t;
    logic [TW-1:0] b_t;
    logic [CW-1:0] hold;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state_q;
  entry_t        mem_q [DEPTH];
  logic          busy_q, done_q, wr_err_q, a_q, b_q, taint_seen_q;
  logic [TW-1:0] a_t_q, b_t_q;
  logic [AW-1:0] first_idx_q, cur_idx_q, last_q;
  logic [CW-1:0] cnt_q;

  entry_t        wr_ent, ent0_d, nxt_ent_d;
  logic          wr_ok_d, expire_d, go_fin_d, advance_d;
  logic [AW-1:0] nxt_idx_d, last_d;
  logic [LW-1:0] len_cl_d;

  // A zero hold still occupies one cycle.
  function automatic logic [CW-1:0] hold_ld(input logic [CW-1:0] h);
    return (h == '0) ? CW'(1) : h;
  endfunction

  assign wr_ent = wr_data;

  always_comb begin
    wr_ok_d   = wr_en && (state_q != RUN);
    // Forward a same-cycle write to entry 0 so start sees the new contents.
    ent0_d    = (wr_ok_d && (wr_addr == '0)) ? wr_ent : mem_q[0];
    nxt_idx_d = (cur_idx_q == last_q) ? '0 : AW'(cur_idx_q + 1'b1);
    nxt_ent_d = mem_q[nxt_idx_d];
    len_cl_d  = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    last_d    = AW'(len_cl_d - 1'b1);
    expire_d  = (cnt_q == CW'(1));
`ifdef IFT_SEQ_LOOP_EN
    go_fin_d  = stop;
`else
    go_fin_d  = expire_d && (cur_idx_q == last_q);
`endif
    advance_d = expire_d;
  end

  // Table storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_d) mem_q[wr_addr] <= wr_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      a_t_q        <= '0;
      b_t_q        <= '0;
      taint_seen_q <= 1'b0;
      first_idx_q  <= '0;
      cur_idx_q    <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= wr_en && (state_q == RUN);
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q      <= RUN;
              busy_q       <= 1'b1;
              cur_idx_q    <= '0;
              last_q       <= last_d;
              cnt_q        <= hold_ld(ent0_d.hold);
              a_q          <= ent0_d.a;
              b_q          <= ent0_d.b;
              a_t_q        <= ent0_d.a_t;
              b_t_q        <= ent0_d.b_t;
              taint_seen_q <= 1'b0;
              first_idx_q  <= '0;
            end
          end
        end
        RUN: begin
          if ((c_t != '0) && !taint_seen_q) begin
            taint_seen_q <= 1'b1;
            first_idx_q  <= cur_idx_q;
          end
          if (go_fin_d) begin
            state_q   <= FIN;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            a_t_q     <= '0;
            b_t_q     <= '0;
            cur_idx_q <= '0;
          end else if (advance_d) begin
            cur_idx_q <= nxt_idx_d;
            cnt_q     <= hold_ld(nxt_ent_d.hold);
            a_q       <= nxt_ent_d.a;
            b_q       <= nxt_ent_d.b;
            a_t_q     <= nxt_ent_d.a_t;
            b_t_q     <= nxt_ent_d.b_t;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_err     = wr_err_q;
  assign a          = a_q;
  assign b          = b_q;
  assign a_t        = a_t_q;
  assign b_t        = b_t_q;
  assign taint_seen = taint_seen_q;
  assign first_idx  = first_idx_q;
  assign cur_idx    = cur_idx_q;

endmodule
